// File: rtl/bcd_dabble_sequencer.sv
// Sequential binary-to-BCD converter (shift-and-add-3) that time-shares a single
// 4-bit comparator across all BCD digits, one digit per cycle.

module FourBitComparator (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       Greater
);
    assign Greater = (A > B);
endmodule

module bcd_dabble_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic [WIDTH-1:0]    Binary,
    output logic                Busy,
    output logic                Done,
    output logic [4*DIGITS-1:0] Bcd
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] work_q, work_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [3:0]       nibble;
    logic [3:0]       nibble_adj;
    logic             greater;
    logic             last_digit;
    logic             last_bit;

    always_comb begin
        nibble = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (digit_idx_q == IDX_W'(d)) nibble = work_q[4*d +: 4];
        end
    end

    FourBitComparator u_cmp (
        .A       (nibble),
        .B       (4'd4),
        .Greater (greater)
    );

    // An adjusted digit never exceeds 12, so the 4-bit add cannot overflow.
    assign nibble_adj = greater ? (nibble + 4'd3) : nibble;
    assign last_digit = (digit_idx_q == IDX_W'(DIGITS - 1));
    assign last_bit   = (bit_cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            digit_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ADJUST;
            ADJUST:  if (last_digit) state_d = SHIFT;
            SHIFT:   state_d = last_bit ? DONE : ADJUST;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_d       = bin_q;
        work_d      = work_q;
        bcd_d       = bcd_q;
        bit_cnt_d   = bit_cnt_q;
        digit_idx_d = digit_idx_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    bin_d       = Binary;
                    work_d      = '0;
                    bit_cnt_d   = '0;
                    digit_idx_d = '0;
                end
            end
            ADJUST: begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (digit_idx_q == IDX_W'(d)) work_d[4*d +: 4] = nibble_adj;
                end
                if (!last_digit) digit_idx_d = digit_idx_q + IDX_W'(1);
            end
            SHIFT: begin
                {work_d, bin_d} = {work_q, bin_q} << 1;
                digit_idx_d     = '0;
                // Capture the final shifted digits so Bcd is valid in the DONE cycle.
                if (last_bit) bcd_d = {work_q[BCD_W-2:0], bin_q[WIDTH-1]};
                else          bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy = (state_q == ADJUST) || (state_q == SHIFT);
        Done = (state_q == DONE);
    end

    assign Bcd = bcd_q;

endmodule

// File: tb/tb_bcd_dabble_sequencer.sv
// Directed bench for bcd_dabble_sequencer: expected BCD values are queued at
// start and checked when Done is seen; timing and boundary cases are checked inline.

module tb_bcd_dabble_sequencer;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                Start;
    logic [WIDTH-1:0]    Binary;
    logic                Busy;
    logic                Done;
    logic [4*DIGITS-1:0] Bcd;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [4*DIGITS-1:0] exp_q[$];

    bcd_dabble_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .Binary (Binary),
        .Busy   (Busy),
        .Done   (Done),
        .Bcd    (Bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every Done pops one expected result.
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            done_cnt++;
            chk("done pulse width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) chk("done without pending start", 32'(exp_q.size()), 32'd1);
            else                   chk("bcd result", 32'(Bcd), 32'(exp_q.pop_front()));
        end
        prev_done = Done;
    end

    task automatic convert(input logic [WIDTH-1:0] v, input string tag);
        int   n;
        logic busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        Start   = 1'b1;
        Binary  = v;
        exp_q.push_back(ref_bcd(int'(v)));
        do begin
            @(negedge clk);
            n++;
            Start  = 1'b0;
            Binary = WIDTH'($urandom);
            if (n <= 32 && (Busy !== 1'b1 || Done !== 1'b0)) busy_ok = 1'b0;
        end while (Done !== 1'b1 && n < 40);
        chk({tag, " done latency"}, 32'(n), 32'd33);
        chk({tag, " busy window"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy in done"}, 32'(Busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int dq[$];

        // Reset held for two cycles with Start high.
        rst    = 1'b1;
        Start  = 1'b1;
        Binary = 8'd255;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset busy", 32'(Busy), 32'd0);
            chk("reset done", 32'(Done), 32'd0);
            chk("reset bcd", 32'(Bcd), 32'h000);
        end
        rst   = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        chk("post-reset idle", 32'(Busy), 32'd0);

        convert(8'd255, "max");
        convert(8'd0,   "zero");
        convert(8'd5,   "five");
        convert(8'd99,  "ninety-nine");
        convert(8'd100, "hundred");
        convert(8'd128, "one-two-eight");

        // Start pulses during the conversion and in the DONE cycle are ignored.
        d0     = done_cnt;
        Start  = 1'b1;
        Binary = 8'd200;
        exp_q.push_back(ref_bcd(200));
        for (n = 1; n <= 70; n++) begin
            @(negedge clk);
            Start  = (n == 10 || n == 33);
            Binary = 8'd7;
            if (n == 33) chk("ignored start done cycle", 32'(Done), 32'd1);
            if (n == 36) chk("ignored start no restart", 32'(Busy), 32'd0);
        end
        chk("ignored start done count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a conversion aborts it.
        d0     = done_cnt;
        Start  = 1'b1;
        Binary = 8'd77;
        for (n = 1; n <= 15; n++) begin
            @(negedge clk);
            Start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort bcd", 32'(Bcd), 32'h000);
        repeat (40) @(negedge clk);
        chk("abort no done", 32'(done_cnt - d0), 32'd0);
        convert(8'd128, "after abort");

        // Start held high: back-to-back conversions.
        Start  = 1'b1;
        Binary = 8'd42;
        for (int i = 0; i < 3; i++) exp_q.push_back(ref_bcd(42));
        for (n = 1; n <= 101; n++) begin
            @(negedge clk);
            if (Done === 1'b1) dq.push_back(n);
            if (n == 101) Start = 1'b0;
        end
        chk("b2b done count", 32'(dq.size()), 32'd3);
        if (dq.size() == 3) begin
            chk("b2b done 1", 32'(dq[0]), 32'd33);
            chk("b2b done 2", 32'(dq[1]), 32'd67);
            chk("b2b done 3", 32'(dq[2]), 32'd101);
        end
        @(negedge clk);
        chk("b2b stops", 32'(Busy), 32'd0);

        for (int v = 0; v < 256; v++) convert(WIDTH'(v), "sweep");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
